// File: rtl/data_stack_pkg.sv
// Shared definitions for the data stack: opcode encoding and default sizing.
package data_stack_pkg;

  localparam int DEF_WORD_LEN    = 8;
  localparam int DEF_STACK_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_DUP   = 3'd3,
    OP_SWAP  = 3'd4,
    OP_DROP2 = 3'd5,
    OP_CLR   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

endpackage

// File: rtl/data_stack_regfile.sv
// Stack storage: one write port, two combinational read ports. No reset on contents.
module stack_regfile
  import data_stack_pkg::*;
#(
  parameter int WORD_LEN    = DEF_WORD_LEN,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(STACK_DEPTH)-1:0] waddr,
  input  logic [WORD_LEN-1:0]            wdata,
  input  logic [$clog2(STACK_DEPTH)-1:0] raddr1,
  input  logic [$clog2(STACK_DEPTH)-1:0] raddr2,
  output logic [WORD_LEN-1:0]            rdata1,
  output logic [WORD_LEN-1:0]            rdata2
);

  logic [STACK_DEPTH-1:0][WORD_LEN-1:0] mem;

  // single write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/data_stack.sv
// Single-cycle data stack. The top two entries live in the tos/nos registers;
// the array holds everything below them, so ptr advances only when nos spills.
// Optional macro DATA_STACK_GUARD_EN: violating ops change nothing but err.
// Without it, PUSH/DUP on full overwrite the oldest entry (pointer wraps);
// every other violating op also leaves the stack untouched and sets err.
module data_stack
  import data_stack_pkg::*;
#(
  parameter int WORD_LEN    = DEF_WORD_LEN,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         op_valid,
  input  logic [2:0]                   op,
  input  logic [WORD_LEN-1:0]          din,
  output logic [WORD_LEN-1:0]          tos,
  output logic [WORD_LEN-1:0]          nos,
  output logic [$clog2(STACK_DEPTH):0] count,
  output logic                         empty,
  output logic                         full,
  output logic                         err
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);

  op_e              opc;
  logic [PW-1:0]    ptr, ptr_nxt, ra1, ra2;
  logic [CW-1:0]    cnt_nxt;
  logic [WORD_LEN-1:0] tos_nxt, nos_nxt, rd1, rd2;
  logic             err_nxt, we, viol, apply;
  logic             has1, has2, has3, has4, is_full, is_push;

  assign opc     = op_valid ? op_e'(op) : OP_NOP;
  assign has1    = (32'(count) >= 32'd1);
  assign has2    = (32'(count) >= 32'd2);
  assign has3    = (32'(count) >= 32'd3);
  assign has4    = (32'(count) >= 32'd4);
  assign is_full = (count == DEPTH_C);
  assign is_push = (opc == OP_PUSH) || (opc == OP_DUP);
  assign ra1     = ptr - PW'(1);
  assign ra2     = ptr - PW'(2);

  // precondition check
  always_comb begin
    viol = 1'b0;
    case (opc)
      OP_PUSH:           viol = is_full;
      OP_DUP:            viol = is_full || !has1;
      OP_POP:            viol = !has1;
      OP_SWAP, OP_DROP2: viol = !has2;
      default:           viol = 1'b0;
    endcase
  end

`ifdef DATA_STACK_GUARD_EN
  assign apply = !viol;
`else
  assign apply = !viol || (is_push && is_full);
`endif

  stack_regfile #(.WORD_LEN(WORD_LEN), .STACK_DEPTH(STACK_DEPTH)) u_rf (
    .clk    (clk),
    .we     (we),
    .waddr  (ptr),
    .wdata  (nos),
    .raddr1 (ra1),
    .raddr2 (ra2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // next-state for pointer, count, top registers and error flag
  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = count;
    tos_nxt = tos;
    nos_nxt = nos;
    we      = 1'b0;
    err_nxt = err | viol;
    if (opc == OP_CLR) begin
      ptr_nxt = '0;
      cnt_nxt = '0;
      tos_nxt = '0;
      nos_nxt = '0;
      err_nxt = 1'b0;
    end else if (apply) begin
      case (opc)
        OP_PUSH, OP_DUP: begin
          tos_nxt = (opc == OP_PUSH) ? din : tos;
          nos_nxt = tos;
          // old nos spills into the array only if it was a real entry
          if (has2) begin
            we      = 1'b1;
            ptr_nxt = ptr + PW'(1);
          end
          if (!is_full) cnt_nxt = count + CW'(1);
        end
        OP_POP: begin
          tos_nxt = nos;
          nos_nxt = has3 ? rd1 : '0;
          if (has3) ptr_nxt = ptr - PW'(1);
          cnt_nxt = count - CW'(1);
        end
        OP_SWAP: begin
          tos_nxt = nos;
          nos_nxt = tos;
        end
        OP_DROP2: begin
          tos_nxt = has3 ? rd1 : '0;
          nos_nxt = has4 ? rd2 : '0;
          if (has4)      ptr_nxt = ptr - PW'(2);
          else if (has3) ptr_nxt = ptr - PW'(1);
          cnt_nxt = count - CW'(2);
        end
        default: ;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr   <= '0;
      count <= '0;
      tos   <= '0;
      nos   <= '0;
      err   <= 1'b0;
    end else begin
      ptr   <= ptr_nxt;
      count <= cnt_nxt;
      tos   <= tos_nxt;
      nos   <= nos_nxt;
      err   <= err_nxt;
    end
  end

  assign empty = (count == '0);
  assign full  = is_full;

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: queue-based reference model, per-cycle
// compare process, directed checks with literal expectations, random ops.
module tb_data_stack;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         op_valid = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] din = '0;
  logic [W-1:0] tos, nos;
  logic [3:0]   count;
  logic         empty, full, err;

  int n_vec = 0;
  int n_bad = 0;

  logic [W-1:0] mq[$];
  logic         m_err = 1'b0;

  always #5 clk = ~clk;

  data_stack #(.WORD_LEN(W), .STACK_DEPTH(D)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .op_valid (op_valid),
    .op       (op),
    .din      (din),
    .tos      (tos),
    .nos      (nos),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .err      (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] m_tos();
    return (mq.size() >= 1) ? mq[mq.size()-1] : '0;
  endfunction

  function automatic logic [W-1:0] m_nos();
    return (mq.size() >= 2) ? mq[mq.size()-2] : '0;
  endfunction

  // Reference: stack as a queue, top at the back.
  function automatic void model_apply(input logic v, input logic [2:0] o, input logic [W-1:0] d);
    int n;
    bit viol;
    logic [W-1:0] a, b;
    n = mq.size();
    if (!v) return;
    if (o == 3'd6) begin
      mq.delete();
      m_err = 1'b0;
      return;
    end
    case (o)
      3'd1:       viol = (n == D);
      3'd2:       viol = (n < 1);
      3'd3:       viol = (n < 1) || (n == D);
      3'd4, 3'd5: viol = (n < 2);
      default:    viol = 1'b0;
    endcase
    if (viol) m_err = 1'b1;
`ifdef DATA_STACK_GUARD_EN
    if (viol) return;
`else
    if (viol && !((o == 3'd1 || o == 3'd3) && n == D)) return;
`endif
    case (o)
      3'd1: mq.push_back(d);
      3'd3: begin a = mq[n-1]; mq.push_back(a); end
      3'd2: void'(mq.pop_back());
      3'd4: begin
        a = mq.pop_back();
        b = mq.pop_back();
        mq.push_back(a);
        mq.push_back(b);
      end
      3'd5: begin void'(mq.pop_back()); void'(mq.pop_back()); end
      default: ;
    endcase
    if (mq.size() > D) void'(mq.pop_front());
  endfunction

  // per-cycle compare of all outputs against the model
  always @(negedge clk) begin
    chk("cyc_tos",   32'(tos),   32'(m_tos()));
    chk("cyc_nos",   32'(nos),   32'(m_nos()));
    chk("cyc_count", 32'(count), 32'(mq.size()));
    chk("cyc_empty", 32'(empty), 32'(mq.size() == 0));
    chk("cyc_full",  32'(full),  32'(mq.size() == D));
    chk("cyc_err",   32'(err),   32'(m_err));
  end

  task automatic step(input logic v, input logic [2:0] o, input logic [W-1:0] d);
    op_valid = v;
    op       = o;
    din      = d;
    @(posedge clk);
    if (rstn) model_apply(v, o, d);
    #1;
  endtask

  initial begin
    logic [2:0] ro;
    // reset state, checked while clock is running and reset held
    #2;
    chk("rst_tos",   32'(tos),   32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full",  32'(full),  32'h0);
    chk("rst_err",   32'(err),   32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // push two, swap, pop
    step(1, 3'd1, 8'h11);
    step(1, 3'd1, 8'h22);
    chk("p2_tos", 32'(tos), 32'h22);
    chk("p2_nos", 32'(nos), 32'h11);
    chk("p2_count", 32'(count), 32'd2);
    chk("p2_empty", 32'(empty), 32'h0);
    step(1, 3'd4, 8'h00);
    chk("swap_tos", 32'(tos), 32'h11);
    chk("swap_nos", 32'(nos), 32'h22);
    step(1, 3'd2, 8'h00);
    chk("pop_tos", 32'(tos), 32'h22);
    chk("pop_count", 32'(count), 32'd1);

    // fill to full, then overflow
    step(1, 3'd6, 8'h00);
    for (int i = 1; i <= 8; i++) step(1, 3'd1, 8'(i));
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_err", 32'(err), 32'h0);
    step(1, 3'd1, 8'h09);
    chk("ovf_full", 32'(full), 32'h1);
    chk("ovf_err", 32'(err), 32'h1);
    chk("ovf_count", 32'(count), 32'd8);
`ifdef DATA_STACK_GUARD_EN
    chk("ovf_tos", 32'(tos), 32'h08);
`else
    chk("ovf_tos", 32'(tos), 32'h09);
`endif

    // underflow on empty, then clear
    step(1, 3'd6, 8'h00);
    chk("clr_err", 32'(err), 32'h0);
    step(1, 3'd2, 8'h00);
    chk("unf_err", 32'(err), 32'h1);
    chk("unf_count", 32'(count), 32'd0);
    chk("unf_tos", 32'(tos), 32'h0);
    step(1, 3'd6, 8'h00);
    chk("unf_clr_err", 32'(err), 32'h0);

    // push, dup, drop2
    step(1, 3'd1, 8'h5A);
    chk("pd_c1", 32'(count), 32'd1);
    chk("pd_t1", 32'(tos), 32'h5A);
    step(1, 3'd3, 8'h00);
    chk("pd_c2", 32'(count), 32'd2);
    chk("pd_t2", 32'(tos), 32'h5A);
    step(1, 3'd5, 8'h00);
    chk("pd_c0", 32'(count), 32'd0);
    chk("pd_t0", 32'(tos), 32'h0);
    chk("pd_err", 32'(err), 32'h0);

    // reset asserted mid-cycle during a PUSH abandons it
    step(1, 3'd1, 8'h44);
    op_valid = 1'b1; op = 3'd1; din = 8'h33;
    #2 rstn = 1'b0;
    mq.delete();
    m_err = 1'b0;
    #1;
    chk("mrst_tos", 32'(tos), 32'h0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_empty", 32'(empty), 32'h1);
    @(posedge clk);
    #1 rstn = 1'b1;
    op_valid = 1'b0;
    chk("mrst_after_count", 32'(count), 32'd0);
    chk("mrst_after_err", 32'(err), 32'h0);
    step(1, 3'd1, 8'h77);
    chk("mrst_push_count", 32'(count), 32'd1);
    chk("mrst_push_tos", 32'(tos), 32'h77);

    // random operations
    for (int i = 0; i < 3000; i++) begin
      ro = 3'($urandom_range(0, 7));
      if (ro == 3'd6 && ($urandom_range(0, 7) != 0)) ro = 3'd1;
      step(($urandom_range(0, 9) != 0), ro, 8'($urandom));
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_stack.md
DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 SHALL have parameter WORD_LEN, default 8, data word width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 8, number of entries; SHALL be a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, rising-edge clock; this is the block's only clock.
REQ-004 SHALL have port rstn, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port op_valid, input, 1, an operation is present this cycle.
REQ-006 SHALL have port op, input, 3, opcode: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 DROP2, 6 CLR, 7 reserved (treated as NOP).
REQ-007 SHALL have port din, input, WORD_LEN, data word for PUSH.
REQ-008 SHALL have port tos, output, WORD_LEN, registered top-of-stack value; 0 when empty.
REQ-009 SHALL have port nos, output, WORD_LEN, registered next-on-stack value; 0 when count < 2.
REQ-010 SHALL have port count, output, $clog2(STACK_DEPTH)+1, number of valid entries.
REQ-011 SHALL have port empty, output, 1, high when count == 0.
REQ-012 SHALL have port full, output, 1, high when count == STACK_DEPTH.
REQ-013 SHALL have port err, output, 1, sticky overflow/underflow flag.

Function
REQ-014 SHALL execute every accepted op in one cycle; tos, nos and count SHALL reflect the op at the next rising edge.
REQ-015 SHALL accept an op only when op_valid is high; op_valid low SHALL equal NOP.
REQ-016 PUSH SHALL write din as the new top and increment count.
REQ-017 POP SHALL remove the top and decrement count; the popped value is the tos presented before the edge.
REQ-018 DUP SHALL push a copy of tos.
REQ-019 SWAP SHALL exchange tos and nos; count SHALL be unchanged.
REQ-020 DROP2 SHALL remove two entries.
REQ-021 CLR SHALL set count to 0 and set tos and nos to 0; stored words need not be cleared; err SHALL also be cleared.
REQ-022 Preconditions: PUSH/DUP need a non-full stack; POP needs count >= 1; DUP needs count >= 1; SWAP and DROP2 need count >= 2.
REQ-023 A violated precondition SHALL set err at the next edge; the state update is defined in REQ-029/REQ-030.
REQ-024 Storage SHALL be a STACK_DEPTH-entry register array indexed by a stack pointer.
REQ-025 tos and nos SHALL be driven from registers updated alongside the array; there SHALL be no combinational path from din to tos.

Reset
REQ-026 While rstn is low, count SHALL be 0, tos 0, nos 0, err 0, empty 1 and full 0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL abandon the op; the first op after release SHALL see an empty stack.
REQ-028 Array contents SHALL not require reset.

Configuration
REQ-029 With macro DATA_STACK_GUARD_EN defined, a violating op SHALL leave the array, tos, nos and count unchanged; only err is set.
REQ-030 Without DATA_STACK_GUARD_EN:
- the pointer SHALL wrap modulo STACK_DEPTH;
- PUSH on full SHALL overwrite the oldest entry, with count held at STACK_DEPTH;
- POP on empty SHALL keep count at 0;
- err SHALL still be set.

Structure
REQ-031 A shared package SHALL hold the opcode enumeration and the default WORD_LEN and STACK_DEPTH constants.
REQ-032 The array SHALL be one sub-module, stack_regfile: 1 write port and 2 read ports (ptr-1, ptr-2); the pointer and control logic SHALL stay in data_stack.

Verification
REQ-033 Reset, then PUSH 0x11, PUSH 0x22 -> tos=0x22, nos=0x11, count=2, empty=0.
REQ-034 After REQ-033, SWAP then POP -> after SWAP tos=0x11, nos=0x22; after POP tos=0x22, count=1.
REQ-035 PUSH 8 values 0x01..0x08, then PUSH 0x09 -> full=1, err=1; with GUARD: tos=0x08, count=8; without GUARD: tos=0x09, count=8.
REQ-036 Empty stack, POP -> err=1, count=0, tos=0; then CLR -> err=0.
REQ-037 PUSH 0x5A, DUP, DROP2 -> count 1, 2, 0; tos 0x5A, 0x5A, 0; no err.
REQ-038 PUSH 0x33 with rstn pulsed low mid-cycle -> outputs 0 immediately, count=0 after release, no spurious err.
